shift_chain: RTL and testbench

SHIFT_CHAIN -- requirements
Module: shift_chain

---
 rtl/shift_chain_pkg.sv | 14 +
 rtl/shift_chain_if.sv | 34 +++
 rtl/shift_stage.sv | 52 +++++
 rtl/shift_chain.sv | 85 ++++++++
 tb/tb_shift_chain.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/shift_chain_pkg.sv
// Shared definitions for the shift chain: operation modes and default geometry.
package shift_chain_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_chain_if.sv
// Control/data bundle of the shift chain; master drives mode and data, slave returns chain state.
interface shift_chain_if
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int CW = $clog2(DEPTH + 1);

    // No ready: the chain accepts every cycle. shin_valid marks shin as a real
    // element (else a bubble); out_valid is the valid bit of the last stage.
    logic [1:0]             mode;
    logic [WIDTH-1:0]       shin;
    logic                   shin_valid;
    logic [DEPTH*WIDTH-1:0] pload;
    logic [WIDTH-1:0]       out;
    logic                   out_valid;
    logic [DEPTH*WIDTH-1:0] taps;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;

    modport master (
        output mode, shin, shin_valid, pload,
        input  out, out_valid, taps, count, full, empty
    );

    modport slave (
        input  mode, shin, shin_valid, pload,
        output out, out_valid, taps, count, full, empty
    );

endinterface

// File: rtl/shift_stage.sv
// One chain stage: WIDTH data bits plus a valid bit, with a mode-selected next value.
module shift_stage
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] shift_data,
    input  logic             shift_valid,
    input  logic [WIDTH-1:0] rot_data,
    input  logic             rot_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] data_d;
    logic             valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        case (mode)
            MODE_SHIFT: begin
                data_d  = shift_data;
                valid_d = shift_valid;
            end
            MODE_LOAD: begin
                data_d  = load_data;
                valid_d = 1'b1;
            end
            MODE_ROTATE: begin
                data_d  = rot_data;
                valid_d = rot_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/shift_chain.sv
// DEPTH-stage shift/rotate/load chain with a tracked count of valid elements.
module shift_chain
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    shift_chain_if.slave  sc
);

    localparam int CW = $clog2(DEPTH + 1);

    mode_e            mode_sel;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    assign mode_sel = mode_e'(sc.mode);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            // Stage 0 shifts in from shin but rotates in from the last stage.
            shift_stage #(.WIDTH(WIDTH)) u_stage (
                .clk         (clk),
                .reset       (reset),
                .mode        (mode_sel),
                .shift_data  (sc.shin),
                .shift_valid (sc.shin_valid),
                .rot_data    (stage_data[DEPTH-1]),
                .rot_valid   (stage_valid[DEPTH-1]),
                .load_data   (sc.pload[0 +: WIDTH]),
                .data_q      (stage_data[0]),
                .valid_q     (stage_valid[0])
            );
        end else begin : g_body
            shift_stage #(.WIDTH(WIDTH)) u_stage (
                .clk         (clk),
                .reset       (reset),
                .mode        (mode_sel),
                .shift_data  (stage_data[i-1]),
                .shift_valid (stage_valid[i-1]),
                .rot_data    (stage_data[i-1]),
                .rot_valid   (stage_valid[i-1]),
                .load_data   (sc.pload[i*WIDTH +: WIDTH]),
                .data_q      (stage_data[i]),
                .valid_q     (stage_valid[i])
            );
        end
    end

    // Count is tracked incrementally; it never wraps because it mirrors the valids.
    always_comb begin
        count_d = count_q;
        case (mode_sel)
            MODE_SHIFT: count_d = count_q + CW'(sc.shin_valid) - CW'(stage_valid[DEPTH-1]);
            MODE_LOAD:  count_d = CW'(DEPTH);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        sc.taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sc.taps[i*WIDTH +: WIDTH] = stage_data[i];
        end
    end

    assign sc.out       = stage_data[DEPTH-1];
    assign sc.out_valid = stage_valid[DEPTH-1];
    assign sc.count     = count_q;
    assign sc.full      = (count_q == CW'(DEPTH));
    assign sc.empty     = (count_q == '0);

endmodule

// File: tb/tb_shift_chain.sv
// Directed bench for shift_chain (WIDTH=8, DEPTH=4): vector table plus rotate and reset sequences.
module tb_shift_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] LOAD   = 2'b10;
    localparam logic [1:0] ROTATE = 2'b11;

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [7:0]  shin;
        logic        sv;
        logic [31:0] pload;
        logic [31:0] exp_taps;
        logic [7:0]  exp_out;
        logic        exp_ov;
        logic [2:0]  exp_count;
        logic        exp_full;
        logic        exp_empty;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [WIDTH-1:0] exp_q [$];

    shift_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) sc ();

    shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sc    (sc)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic [1:0] m, input logic [7:0] d,
                        input logic v, input logic [31:0] p);
        reset         = r;
        sc.mode       = m;
        sc.shin       = d;
        sc.shin_valid = v;
        sc.pload      = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] taps, input logic [7:0] o,
                             input logic ov, input logic [2:0] cnt, input logic f, input logic e);
        chk({tag, " taps"},      sc.taps, taps);
        chk({tag, " out"},       32'(sc.out), 32'(o));
        chk({tag, " out_valid"}, 32'(sc.out_valid), 32'(ov));
        chk({tag, " count"},     32'(sc.count), 32'(cnt));
        chk({tag, " full"},      32'(sc.full), 32'(f));
        chk({tag, " empty"},     32'(sc.empty), 32'(e));
    endtask

    vec_t vecs [16];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b1;
        sc.mode       = HOLD;
        sc.shin       = '0;
        sc.shin_valid = 1'b0;
        sc.pload      = '0;

        // Taps are listed stage3..stage0 (stage 3 in the top byte).
        //            rst   mode    shin   sv    pload           taps           out    ov    cnt   full  empty
        vecs[0]  = '{1'b1, LOAD,   8'h00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, HOLD,   8'h99, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, HOLD,   8'h99, 1'b1, 32'h0000_0000, 32'h0000_0000, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, HOLD,   8'h00, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, SHIFT,  8'h11, 1'b1, 32'h0000_0000, 32'h0000_0011, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, SHIFT,  8'h22, 1'b1, 32'h0000_0000, 32'h0000_1122, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, SHIFT,  8'h33, 1'b1, 32'h0000_0000, 32'h0011_2233, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, SHIFT,  8'h44, 1'b1, 32'h0000_0000, 32'h1122_3344, 8'h11, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, SHIFT,  8'h55, 1'b1, 32'h0000_0000, 32'h2233_4455, 8'h22, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, SHIFT,  8'h66, 1'b0, 32'h0000_0000, 32'h3344_5566, 8'h33, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, HOLD,   8'hAA, 1'b1, 32'hDEAD_BEEF, 32'h3344_5566, 8'h33, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, LOAD,   8'h00, 1'b0, 32'h4433_2211, 32'h4433_2211, 8'h44, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[12] = '{1'b0, ROTATE, 8'h00, 1'b0, 32'h0000_0000, 32'h3322_1144, 8'h33, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[13] = '{1'b1, LOAD,   8'h00, 1'b0, 32'h8765_4321, 32'h0000_0000, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, SHIFT,  8'h77, 1'b0, 32'h0000_0000, 32'h0000_0077, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, ROTATE, 8'h00, 1'b1, 32'h0000_0000, 32'h0000_7700, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].mode, vecs[i].shin, vecs[i].sv, vecs[i].pload);
            check_all($sformatf("vec%0d", i), vecs[i].exp_taps, vecs[i].exp_out,
                      vecs[i].exp_ov, vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_empty);
        end

        // Two valid elements, then four rotations must return the original contents.
        step(1'b1, HOLD, 8'h00, 1'b0, 32'h0);
        step(1'b0, SHIFT, 8'hAA, 1'b1, 32'h0);
        step(1'b0, SHIFT, 8'hBB, 1'b1, 32'h0);
        check_all("rot_start", 32'h0000_AABB, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        exp_q.push_back(8'h00);
        for (int r = 0; r < 4; r++) begin
            step(1'b0, ROTATE, 8'h5A, 1'b1, 32'h0);
            chk($sformatf("rot%0d out", r), 32'(sc.out), 32'(exp_q.pop_front()));
            chk($sformatf("rot%0d count", r), 32'(sc.count), 32'd2);
        end
        check_all("rot_end", 32'h0000_AABB, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0);
        step(1'b0, SHIFT, 8'hCC, 1'b1, 32'h0);
        step(1'b0, SHIFT, 8'hDD, 1'b1, 32'h0);
        check_all("rot_valids", 32'hAABB_CCDD, 8'hAA, 1'b1, 3'd4, 1'b1, 1'b0);

        // Reset beats LOAD in the middle of a shift stream.
        step(1'b1, HOLD, 8'h00, 1'b0, 32'h0);
        step(1'b0, SHIFT, 8'h01, 1'b1, 32'h0);
        step(1'b0, SHIFT, 8'h02, 1'b1, 32'h0);
        step(1'b0, SHIFT, 8'h03, 1'b1, 32'h0);
        check_all("mid_stream", 32'h0001_0203, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0);
        step(1'b1, LOAD, 8'h04, 1'b1, 32'hFFFF_FFFF);
        check_all("reset_load", 32'h0000_0000, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);

        // Shift through a full chain with bubbles draining it to empty.
        step(1'b0, LOAD, 8'h00, 1'b0, 32'hA1B2_C3D4);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, SHIFT, 8'hE0, 1'b0, 32'h0);
            chk($sformatf("drain%0d count", k), 32'(sc.count), 32'(3 - k));
        end
        check_all("drained", 32'hE0E0_E0E0, 8'hE0, 1'b0, 3'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
